// File: rtl/bft_leaf_port_0.sv
// Generic FIFO with first-word-fall-through head and registered full/empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: the caller must push only when !full and pop only when !empty.
module bft_leaf_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] push_dat,
  input  logic             pop,
  output logic [width-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int pw = $clog2(depth);
  localparam logic [pw:0]   full_cnt = (pw+1)'(depth);
  localparam logic [pw:0]   one_cnt  = (pw+1)'(1);
  localparam logic [pw-1:0] one_ptr  = pw'(1);

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [pw:0]      count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + one_ptr;
      if (pop)  rd_ptr <= rd_ptr + one_ptr;
      case ({push, pop})
        2'b10:   count <= count + one_cnt;
        2'b01:   count <= count - one_cnt;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == full_cnt);
  assign empty    = (count == '0);
endmodule

// Leaf port: PE injection via FIFO onto the switch, ejection of local packets.
// Latency: inject 2 cycles min, bounce 1 cycle, eject visible 1 cycle after arrival.
// Backpressure: din_ready drops when injection FIFO full; a full ejection FIFO bounces arrivals.
module bft_leaf_port_0 #(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter logic [$clog2(num_leaves)-1:0] addr = 1'b0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int in_depth   = 4,
  parameter int out_depth  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [p_sz-1:0]       bus_i,
  output logic [p_sz-1:0]       bus_o,
  input  logic [p_sz-2:0]       din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [payload_sz-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [15:0]           bounce_cnt
);
  localparam int aw = $clog2(num_leaves);

  logic          in_vld;
  logic [aw-1:0] in_dest;
  logic          eject;
  logic          bounce;

  logic            inj_full;
  logic            inj_empty;
  logic            inj_pop;
  logic [p_sz-2:0] inj_head;
  logic            ej_full;
  logic            ej_empty;

  assign in_vld  = bus_i[p_sz-1];
  assign in_dest = bus_i[p_sz-2:payload_sz];

  // Room is judged on the registered count, so a same-cycle pop never makes space.
  assign eject   = in_vld && (in_dest == addr) && !ej_full;
  assign bounce  = in_vld && !eject;
  assign inj_pop = !bounce && !inj_empty;

  assign din_ready  = !inj_full;
  assign dout_valid = !ej_empty;

  bft_leaf_fifo #(.width(p_sz-1), .depth(in_depth)) u_inj_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (din_valid && din_ready),
    .push_dat (din),
    .pop      (inj_pop),
    .head_dat (inj_head),
    .full     (inj_full),
    .empty    (inj_empty)
  );

  bft_leaf_fifo #(.width(payload_sz), .depth(out_depth)) u_ej_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (eject),
    .push_dat (bus_i[payload_sz-1:0]),
    .pop      (dout_valid && dout_ready),
    .head_dat (dout),
    .full     (ej_full),
    .empty    (ej_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_o      <= '0;
      bounce_cnt <= '0;
    end else begin
      if (bounce) begin
        bus_o <= bus_i;
        if (bounce_cnt != 16'hFFFF) bounce_cnt <= bounce_cnt + 16'd1;
      end else if (!inj_empty) begin
        bus_o <= {1'b1, inj_head};
      end else begin
        bus_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bft_leaf_port_0.sv
module tb_bft_leaf_port_0;
  logic        clk;
  logic        reset_n;
  logic [10:0] bus_i;
  logic [10:0] bus_o;
  logic [9:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] bounce_cnt;

  int checks = 0;
  int errors = 0;

  bft_leaf_port_0 #(
    .num_leaves (4),
    .payload_sz (8),
    .addr       (2'd2),
    .p_sz       (11),
    .in_depth   (4),
    .out_depth  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus_i      (bus_i),
    .bus_o      (bus_o),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bounce_cnt (bounce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    int rx;
    logic acc;
    logic saw_full;
    logic [10:0] drv;

    reset_n    = 1'b0;
    bus_i      = '0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;
    check("rst_bus_o", bus_o, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_bounce_cnt", bounce_cnt, 0);
    step();
    reset_n = 1'b1;
    step();

    // Inject path
    din = {2'd1, 8'hA5};
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("inj_k", bus_o, 0);
    step();
    check("inj_k1", bus_o, 11'h5A5);
    step();
    check("inj_k2", bus_o, 0);

    // Eject path
    bus_i = 11'h6C3;
    step();
    bus_i = '0;
    check("ej_valid", dout_valid, 1);
    check("ej_dout", dout, 8'hC3);
    check("ej_no_bus", bus_o, 0);
    step();
    check("ej_hold_valid", dout_valid, 1);
    check("ej_hold_dout", dout, 8'hC3);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("ej_popped", dout_valid, 0);

    // Misroute bounce blocks injection for one cycle
    din = {2'd3, 8'h11};
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    bus_i = 11'h43C;
    step();
    bus_i = '0;
    check("bnc_bus_o", bus_o, 11'h43C);
    check("bnc_cnt", bounce_cnt, 1);
    step();
    check("bnc_inj", bus_o, 11'h711);
    step();
    check("bnc_idle", bus_o, 0);

    // Ejection full: arrival bounces even with a same-cycle pop
    for (int i = 1; i <= 4; i++) begin
      bus_i = 11'h600 | 11'(i);
      step();
    end
    bus_i = 11'h6FF;
    dout_ready = 1'b1;
    check("full_head", dout, 8'h01);
    check("full_valid", dout_valid, 1);
    step();
    bus_i = '0;
    check("full_bus_o", bus_o, 11'h6FF);
    check("full_cnt", bounce_cnt, 2);
    for (int i = 2; i <= 4; i++) begin
      check("full_drain_valid", dout_valid, 1);
      check("full_drain_dout", dout, 32'(i));
      step();
    end
    check("full_drained", dout_valid, 0);
    dout_ready = 1'b0;

    // Wrap and backpressure with a bounce every other cycle
    pushed = 0;
    rx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 60; c++) begin
      drv = (c % 2 == 0) ? (11'h400 | 11'(c)) : 11'h000;
      bus_i = drv;
      din_valid = (pushed < 16);
      din = {2'd1, 8'(pushed)};
      acc = din_valid && din_ready;
      step();
      if (acc) pushed++;
      if (drv[10]) begin
        check("wrap_bounce", bus_o, drv);
      end else if (bus_o[10]) begin
        check("wrap_order", bus_o, {1'b1, 2'd1, 8'(rx)});
        rx++;
      end
      check("wrap_din_ready", din_ready, 32'((pushed - rx) < 4));
      if (!din_ready) saw_full = 1'b1;
    end
    bus_i = '0;
    din_valid = 1'b0;
    step();
    check("wrap_pushed", pushed, 16);
    check("wrap_rx", rx, 16);
    check("wrap_saw_full", saw_full, 1);
    check("wrap_idle", bus_o, 0);
    check("wrap_bounces", bounce_cnt, 32);

    // Reset mid-traffic: 2 queued ejections, 3 queued injections
    bus_i = 11'h611;
    step();
    bus_i = 11'h622;
    step();
    bus_i = 11'h401;
    for (int i = 0; i < 3; i++) begin
      din = {2'd1, 8'hA0 + 8'(i)};
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    bus_i = '0;
    check("mid_pre_din_ready", din_ready, 1);
    check("mid_pre_dout_valid", dout_valid, 1);
    check("mid_pre_dout", dout, 8'h11);
    check("mid_pre_bus_o", bus_o, 11'h401);
    check("mid_pre_cnt", bounce_cnt, 35);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_bus_o", bus_o, 0);
    check("mid_rst_din_ready", din_ready, 1);
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_cnt", bounce_cnt, 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_after_bus_o", bus_o, 0);
      check("mid_after_dout_valid", dout_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bft_leaf_port_0.md
# bft_leaf_port_0

Leaf-side network port between one processing element (PE) and the leaf-facing bus of a level-0 `t_switch_0` in the deflection-routed butterfly-fat-tree.
- Injects PE packets onto the switch's input bus through a buffer FIFO.
- Ejects packets addressed to this leaf into a delivery FIFO.
- Never drops a packet: misrouted packets, and packets arriving while the delivery FIFO is full, are bounced straight back into the network.
- At most one packet leaves per cycle, so the switch never sees more than one packet per leaf link per cycle.

## Interface
Parameters:
- `num_leaves`, 2: leaves in the tree.
- `payload_sz`, 1: payload bits.
- `addr`, 1'b0: this leaf's address.
- `p_sz`, `1+$clog2(num_leaves)+payload_sz`: packet width. Packet layout is `[p_sz-1]` valid, `[p_sz-2:payload_sz]` dest, `[payload_sz-1:0]` payload.
- `in_depth`, 4: injection FIFO depth. Power of two, ≥2.
- `out_depth`, 4: ejection FIFO depth. Power of two, ≥2.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `bus_i`  in  p_sz: packet from the switch (switch leaf output).
- `bus_o`  out  p_sz: registered packet to the switch (switch leaf input).
- `din`  in  p_sz-1: {dest, payload} from the PE.
- `din_valid`  in  1: PE offers `din`.
- `din_ready`  out  1: injection FIFO not full.
- `dout`  out  payload_sz: payload delivered to the PE.
- `dout_valid`  out  1: ejection FIFO not empty.
- `dout_ready`  in  1: PE accepts `dout`.
- `bounce_cnt`  out  16: saturating count of bounced packets.

## Operation
- **Reset (reset_n=0, immediate):**
  - `bus_o`=0, `bounce_cnt`=0.
  - Both FIFOs are emptied, so `din_ready`=1 and `dout_valid`=0.
  - `dout` is don't-care while `dout_valid`=0.
  - Reset mid-operation discards all buffered packets; no partial state survives.
- **Injection FIFO:**
  - Push when `din_valid && din_ready`.
  - `din_ready` = count < in_depth, combinational from registered count only.
- **Ejection FIFO:**
  - Pop when `dout_valid && dout_ready`.
  - `dout` = head payload (first-word-fall-through).
- **Incoming classification**, when `bus_i` valid bit is 1:
  - `eject` if dest == addr and ejection count < out_depth, where count is the registered value at the start of the cycle. A same-cycle pop does not create room.
  - `bounce` otherwise.
  - An eject pushes the payload into the ejection FIFO.
  - Packets with valid bit 0 are ignored, whatever their other bits.
- **Next `bus_o`, strict priority:**
  1. `bounce`: `bus_o` ← `bus_i` unchanged; `bounce_cnt`++ (saturates at 16'hFFFF).
  2. Else, injection FIFO not empty: `bus_o` ← {1'b1, head}; pop.
  3. Else: `bus_o` ← 0.
- **Simultaneous events:**
  - An eject and an injection may occur in the same cycle.
  - A bounce blocks injection for that cycle only; the FIFO head is retained.
  - Push and pop of the same FIFO in one cycle are legal; count is unchanged.
- **Arithmetic:** FIFO pointers are `$clog2(depth)` bits and wrap modulo depth. Counts are `$clog2(depth)+1` bits.

## Timing
- **Inject latency:** `din` accepted at edge k; appears on `bus_o` after edge k+1 at the earliest (1 cycle of FIFO write, 1 cycle of registered output). This holds only if no bounce occurs at k+1.
- **Bounce latency:** `bus_i` sampled at edge k; on `bus_o` after edge k (1-cycle register).
- **Eject latency:** `bus_i` sampled at edge k; `dout_valid`=1 in the cycle after edge k.
- **Throughput:** 1 injection per cycle absent bounces; 1 ejection per cycle.
- **Full/empty boundaries:**
  - Injection full: `din_ready`=0; `din` is ignored.
  - Ejection full: every matching arrival bounces.
  - Empty injection FIFO with no bounce: `bus_o`=0.
- **Wrap-around:** a sustained stream of more than depth items must preserve order with no duplication or loss.

## Test plan
Configuration for all scenarios: num_leaves=4, payload_sz=8, addr=2'd2, p_sz=11, depths 4.

1. **Reset mid-traffic.** Reset with 3 queued injections and 2 queued ejections → `bus_o`=0, `din_ready`=1, `dout_valid`=0, `bounce_cnt`=0 immediately. No queued packet appears afterwards.
2. **Inject path.** `din`={2'd1,8'hA5} accepted at edge k, `bus_i` idle → `bus_o`=11'h5A5 after edge k+1. `bus_o`=0 the cycle after.
3. **Eject path.** `bus_i`=11'h6C3 (valid, dest 2, payload C3) at edge k, `dout_ready`=0 → `dout_valid`=1 and `dout`=8'hC3 from edge k onward, until popped.
4. **Misroute bounce vs injection.**
   - Stimulus: `bus_i`=11'h43C (dest 0) at edge k while the injection FIFO holds {3,8'h11}.
   - Required at edge k: `bus_o`=11'h43C; `bounce_cnt`=1.
   - Required at edge k+1 (bus_i idle): `bus_o`=11'h711.
5. **Ejection full.** With 4 undelivered ejections and `dout_ready`=1 during the same cycle, `bus_i`=11'h6FF → bounced: `bus_o`=11'h6FF, `bounce_cnt`+1. The FIFO still holds the original 4 payloads, in order.
6. **Wrap and backpressure.** Push payloads 8'h00..8'h0F with dest 1 while `bus_i` bounces every other cycle → `din_ready` drops when 4 are queued. All 16 packets exit on `bus_o` in order, none lost, none duplicated.
